hu_audiodec_dma_rd_fetch: RTL and testbench

Upstream input stage of the audio-decoder accelerator: on configuration it fetches the compressed input stream from memory over the ESP 64-bit DMA read interface, buffers the beats, and unpacks each 64-bit beat into two 32-bit words. The words are presented to the decoder core on a valid/ready stream. It owns `dma_read_ctrl_*` / `dma_read_chnl_*`; the write path is handled downstream of the core.

---
 rtl/hu_audiodec_pkg.sv | 16 +
 rtl/hu_audiodec_fifo64.sv | 57 +++++
 rtl/hu_audiodec_dma_rd_fetch.sv | 202 ++++++++++++++++++++
 tb/tb_hu_audiodec_dma_rd_fetch.sv | 479 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hu_audiodec_pkg.sv
// Shared types and constants for the audio-decoder DMA read fetch path.
package hu_audiodec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_DATA  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } fetch_state_t;

    localparam logic [2:0] DMA_SIZE_64     = 3'b011;
    localparam int         BURST_BEATS_DEF = 16;
    localparam int         FIFO_DEPTH_DEF  = 32;

endpackage

// File: rtl/hu_audiodec_fifo64.sv
// 64-bit synchronous FIFO with occupancy count; the count drives the DMA credit check.
module hu_audiodec_fifo64 #(
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [63:0]              push_data,
    input  logic                     pop,
    output logic [63:0]              pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hu_audiodec_dma_rd_fetch.sv
// Fetches the compressed stream over the 64-bit DMA read port and unpacks each
// beat into two 32-bit words for the decoder core.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   IDLE  0  | waiting for conf_done
//   REQ   1  | issue next burst request once the FIFO has room for it
//   DATA  2  | accept the beats of the outstanding burst
//   DRAIN 3  | all beats received, wait for the last word to be consumed
//   DONE  4  | one-cycle fetch_done pulse
module hu_audiodec_dma_rd_fetch
    import hu_audiodec_pkg::*;
#(
    parameter int BURST_BEATS = BURST_BEATS_DEF,
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        conf_done,
    input  logic [31:0] conf_info_src_index,
    input  logic [31:0] conf_info_num_beats,
    output logic        dma_read_ctrl_valid,
    input  logic        dma_read_ctrl_ready,
    output logic [31:0] dma_read_ctrl_data_index,
    output logic [31:0] dma_read_ctrl_data_length,
    output logic [2:0]  dma_read_ctrl_data_size,
    input  logic        dma_read_chnl_valid,
    input  logic [63:0] dma_read_chnl_data,
    output logic        dma_read_chnl_ready,
    output logic        smp_valid,
    output logic [31:0] smp_data,
    output logic        smp_last,
    input  logic        smp_ready,
    output logic        fetch_done,
    output logic [31:0] debug
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t    state;
    fetch_state_t    state_nxt;

    logic [31:0]     cur_index;
    logic [31:0]     remaining;
    logic [31:0]     burst_cnt;
    logic [31:0]     pop_remaining;
    logic [31:0]     req_len;
    logic [31:0]     free_slots;
    logic            ctrl_valid_q;
    logic [31:0]     ctrl_index_q;
    logic [31:0]     ctrl_length_q;
    logic [15:0]     rx_cnt;

    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic [63:0]     fifo_dout;

    logic [63:0]     beat_q;
    logic            beat_valid;
    logic            beat_hi;
    logic            beat_last;

    logic            start;
    logic            req_hs;
    logic            beat_push;
    logic            beat_pop;
    logic            last_hs;

    assign start      = (state == ST_IDLE) && conf_done;
    assign req_hs     = ctrl_valid_q && dma_read_ctrl_ready;
    assign beat_push  = dma_read_chnl_valid && dma_read_chnl_ready;
    assign req_len    = (remaining > 32'(BURST_BEATS)) ? 32'(BURST_BEATS) : remaining;
    assign free_slots = 32'(FIFO_DEPTH) - 32'(fifo_count);

    // The unpacker reloads in the same cycle its upper word is taken, so a
    // steady smp_ready gives one word every cycle.
    assign beat_pop  = !fifo_empty && (!beat_valid || (beat_hi && smp_ready));
    assign smp_valid = beat_valid;
    assign smp_data  = beat_hi ? beat_q[63:32] : beat_q[31:0];
    assign smp_last  = beat_valid && beat_hi && beat_last;
    assign last_hs   = smp_valid && smp_ready && smp_last;

    hu_audiodec_fifo64 #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (beat_push),
        .push_data (dma_read_chnl_data),
        .pop       (beat_pop),
        .pop_data  (fifo_dout),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (conf_done) begin
                    state_nxt = (conf_info_num_beats == 32'd0) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (req_hs) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (beat_push && (burst_cnt == 32'd1)) begin
                    state_nxt = (remaining != 32'd0) ? ST_REQ : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (last_hs) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        dma_read_ctrl_valid       = ctrl_valid_q;
        dma_read_ctrl_data_index  = ctrl_index_q;
        dma_read_ctrl_data_length = ctrl_length_q;
        dma_read_ctrl_data_size   = DMA_SIZE_64;
        dma_read_chnl_ready       = (state == ST_DATA) && !fifo_full;
        fetch_done                = (state == ST_DONE);
        debug                     = {rx_cnt, 13'd0, state};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_index     <= '0;
            remaining     <= '0;
            burst_cnt     <= '0;
            pop_remaining <= '0;
            ctrl_valid_q  <= 1'b0;
            ctrl_index_q  <= '0;
            ctrl_length_q <= '0;
            rx_cnt        <= '0;
            beat_q        <= '0;
            beat_valid    <= 1'b0;
            beat_hi       <= 1'b0;
            beat_last     <= 1'b0;
        end else begin
            if (start) begin
                cur_index     <= conf_info_src_index;
                remaining     <= conf_info_num_beats;
                pop_remaining <= conf_info_num_beats;
                rx_cnt        <= '0;
            end

            // Request is registered and held until accepted; the length is
            // fixed at assertion so the credit it reserved cannot change.
            if (state == ST_REQ) begin
                if (req_hs) begin
                    ctrl_valid_q <= 1'b0;
                    cur_index    <= cur_index + ctrl_length_q;
                    remaining    <= remaining - ctrl_length_q;
                    burst_cnt    <= ctrl_length_q;
                end else if (!ctrl_valid_q && (free_slots >= req_len)) begin
                    ctrl_valid_q  <= 1'b1;
                    ctrl_index_q  <= cur_index;
                    ctrl_length_q <= req_len;
                end
            end

            if (beat_push) begin
                burst_cnt <= burst_cnt - 32'd1;
                rx_cnt    <= rx_cnt + 16'd1;
            end

            if (beat_pop) begin
                beat_q        <= fifo_dout;
                beat_valid    <= 1'b1;
                beat_hi       <= 1'b0;
                beat_last     <= (pop_remaining == 32'd1);
                pop_remaining <= pop_remaining - 32'd1;
            end else if (beat_valid && smp_ready) begin
                if (!beat_hi) begin
                    beat_hi <= 1'b1;
                end else begin
                    beat_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_hu_audiodec_dma_rd_fetch.sv
// Directed bench: DMA memory responder, word sink, one task per scenario.
module tb_hu_audiodec_dma_rd_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        conf_done = 1'b0;
    logic [31:0] conf_info_src_index = '0;
    logic [31:0] conf_info_num_beats = '0;
    logic        dma_read_ctrl_valid;
    logic        dma_read_ctrl_ready;
    logic [31:0] dma_read_ctrl_data_index;
    logic [31:0] dma_read_ctrl_data_length;
    logic [2:0]  dma_read_ctrl_data_size;
    logic        dma_read_chnl_valid;
    logic [63:0] dma_read_chnl_data;
    logic        dma_read_chnl_ready;
    logic        smp_valid;
    logic [31:0] smp_data;
    logic        smp_last;
    logic        smp_ready;
    logic        fetch_done;
    logic [31:0] debug;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int conf_cyc = 0;

    bit ctrl_rdy_en = 1'b1;
    bit chnl_en     = 1'b1;
    bit sink_rdy_en = 1'b1;

    logic [31:0] req_idx[$];
    logic [31:0] req_len[$];
    int          req_words[$];
    logic [31:0] w_data[$];
    bit          w_last[$];
    int          last_hs_cyc = -1;
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          stab_err = 0;

    always #5 clk = ~clk;

    hu_audiodec_dma_rd_fetch dut (
        .clk                       (clk),
        .rst                       (rst),
        .conf_done                 (conf_done),
        .conf_info_src_index       (conf_info_src_index),
        .conf_info_num_beats       (conf_info_num_beats),
        .dma_read_ctrl_valid       (dma_read_ctrl_valid),
        .dma_read_ctrl_ready       (dma_read_ctrl_ready),
        .dma_read_ctrl_data_index  (dma_read_ctrl_data_index),
        .dma_read_ctrl_data_length (dma_read_ctrl_data_length),
        .dma_read_ctrl_data_size   (dma_read_ctrl_data_size),
        .dma_read_chnl_valid       (dma_read_chnl_valid),
        .dma_read_chnl_data        (dma_read_chnl_data),
        .dma_read_chnl_ready       (dma_read_chnl_ready),
        .smp_valid                 (smp_valid),
        .smp_data                  (smp_data),
        .smp_last                  (smp_last),
        .smp_ready                 (smp_ready),
        .fetch_done                (fetch_done),
        .debug                     (debug)
    );

    // Memory content: beat at index i holds {i ^ F0F00000, i}.
    function automatic logic [63:0] beat_of(input logic [31:0] i);
        return {i ^ 32'hF0F0_0000, i};
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] base, input int k);
        logic [31:0] i;
        i = base + 32'(k / 2);
        return (k % 2 == 1) ? (i ^ 32'hF0F0_0000) : i;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // DMA responder: decisions at the falling edge take effect at the next rising edge.
    initial begin
        int          beats_left;
        logic [31:0] nidx;
        beats_left = 0;
        nidx = '0;
        dma_read_ctrl_ready = 1'b0;
        dma_read_chnl_valid = 1'b0;
        dma_read_chnl_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                beats_left = 0;
                dma_read_chnl_valid = 1'b0;
                dma_read_ctrl_ready = 1'b0;
            end else begin
                if (beats_left > 0 && chnl_en) begin
                    dma_read_chnl_valid = 1'b1;
                    dma_read_chnl_data  = beat_of(nidx);
                    if (dma_read_chnl_ready) begin
                        nidx++;
                        beats_left--;
                    end
                end else begin
                    dma_read_chnl_valid = 1'b0;
                end
                dma_read_ctrl_ready = ctrl_rdy_en;
                if (dma_read_ctrl_valid && dma_read_ctrl_ready) begin
                    req_idx.push_back(dma_read_ctrl_data_index);
                    req_len.push_back(dma_read_ctrl_data_length);
                    req_words.push_back(w_data.size());
                    nidx = dma_read_ctrl_data_index;
                    beats_left = int'(dma_read_ctrl_data_length);
                end
            end
        end
    end

    // Word sink and stability monitor.
    initial begin
        logic [32:0] held;
        bit          holding;
        held = '0;
        holding = 1'b0;
        smp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (holding && smp_valid && ({smp_last, smp_data} !== held)) stab_err++;
            smp_ready = sink_rdy_en && !rst;
            if (smp_valid && smp_ready) begin
                w_data.push_back(smp_data);
                w_last.push_back(smp_last);
                if (smp_last) last_hs_cyc = cyc;
            end
            holding = smp_valid && !smp_ready;
            held = {smp_last, smp_data};
            if (fetch_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_logs();
        req_idx.delete();
        req_len.delete();
        req_words.delete();
        w_data.delete();
        w_last.delete();
        last_hs_cyc = -1;
        done_cnt = 0;
        done_cyc = -1;
        stab_err = 0;
    endtask

    task automatic start_job(input logic [31:0] idx, input logic [31:0] n);
        @(negedge clk);
        conf_info_src_index = idx;
        conf_info_num_beats = n;
        conf_done = 1'b1;
        conf_cyc = cyc + 1;
        @(negedge clk);
        conf_done = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (done_cnt == 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (done_cnt == 0) begin
            n_err++;
            $display("FAIL done_timeout: fetch_done not seen within %0d cycles", budget);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length} !== 65'd0) begin
            n_err++;
            $display("FAIL reset_ctrl: got v=%b idx=%h len=%h, want all 0",
                     dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length);
        end
        n_cmp++;
        if (dma_read_ctrl_data_size !== 3'b011) begin
            n_err++;
            $display("FAIL reset_size: got %b want 011", dma_read_ctrl_data_size);
        end
        n_cmp++;
        if ({dma_read_chnl_ready, smp_valid, smp_data, smp_last, fetch_done} !== 36'd0) begin
            n_err++;
            $display("FAIL reset_stream: got chnl_rdy=%b sv=%b sd=%h sl=%b fd=%b, want all 0",
                     dma_read_chnl_ready, smp_valid, smp_data, smp_last, fetch_done);
        end
        n_cmp++;
        if (debug !== 32'd0) begin
            n_err++;
            $display("FAIL reset_debug: got %h want 00000000", debug);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        clear_logs();
        start_job(32'h100, 32'd4);
        wait_done(200);
        n_cmp++;
        if (req_idx.size() != 1 || req_idx[0] !== 32'h100 || req_len[0] !== 32'd4) begin
            n_err++;
            $display("FAIL basic_req: got %0d reqs first=(%h,%0d), want 1 req (100,4)",
                     req_idx.size(), req_idx.size() ? req_idx[0] : 0, req_len.size() ? req_len[0] : 0);
        end
        n_cmp++;
        if (w_data.size() != 8) begin
            n_err++;
            $display("FAIL basic_count: got %0d words want 8", w_data.size());
        end
        for (int k = 0; k < w_data.size() && k < 8; k++) begin
            n_cmp++;
            if (w_data[k] !== exp_word(32'h100, k) || w_last[k] !== (k == 7)) begin
                n_err++;
                $display("FAIL basic_word[%0d]: got %h last=%b want %h last=%b",
                         k, w_data[k], w_last[k], exp_word(32'h100, k), (k == 7));
            end
        end
        n_cmp++;
        if (done_cnt != 1 || done_cyc != last_hs_cyc + 1) begin
            n_err++;
            $display("FAIL basic_done: got %0d pulses at cyc %0d, want 1 pulse at cyc %0d",
                     done_cnt, done_cyc, last_hs_cyc + 1);
        end
    endtask

    task automatic test_multi_burst();
        logic [31:0] base;
        base = 32'h2000;
        clear_logs();
        start_job(base, 32'd40);
        wait_done(1000);
        n_cmp++;
        if (req_idx.size() != 3) begin
            n_err++;
            $display("FAIL multi_nreq: got %0d want 3", req_idx.size());
        end
        for (int r = 0; r < req_idx.size() && r < 3; r++) begin
            n_cmp++;
            if (req_idx[r] !== base + 32'(16 * r) || req_len[r] !== ((r == 2) ? 32'd8 : 32'd16)) begin
                n_err++;
                $display("FAIL multi_req[%0d]: got (%h,%0d) want (%h,%0d)", r, req_idx[r], req_len[r],
                         base + 32'(16 * r), (r == 2) ? 8 : 16);
            end
        end
        n_cmp++;
        if (w_data.size() != 80) begin
            n_err++;
            $display("FAIL multi_count: got %0d words want 80", w_data.size());
        end
        for (int k = 0; k < w_data.size() && k < 80; k++) begin
            n_cmp++;
            if (w_data[k] !== exp_word(base, k) || w_last[k] !== (k == 79)) begin
                n_err++;
                $display("FAIL multi_word[%0d]: got %h last=%b want %h last=%b",
                         k, w_data[k], w_last[k], exp_word(base, k), (k == 79));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] base;
        base = 32'h4000;
        clear_logs();
        sink_rdy_en = 1'b0;
        start_job(base, 32'd64);
        repeat (200) @(negedge clk);
        n_cmp++;
        if (req_idx.size() != 2) begin
            n_err++;
            $display("FAIL bp_withheld: got %0d reqs want 2", req_idx.size());
        end
        n_cmp++;
        if ({dma_read_chnl_ready, dma_read_ctrl_valid} !== 2'b00 || debug !== {16'd32, 16'd1}) begin
            n_err++;
            $display("FAIL bp_stalled: got chnl_rdy=%b ctrl_v=%b debug=%h want 0 0 00200001",
                     dma_read_chnl_ready, dma_read_ctrl_valid, debug);
        end
        sink_rdy_en = 1'b1;
        wait_done(2000);
        n_cmp++;
        if (req_idx.size() != 4 || (req_words.size() > 2 && req_words[2] < 30)) begin
            n_err++;
            $display("FAIL bp_third_req: got %0d reqs, third after %0d words, want 4 reqs, third after >=30",
                     req_idx.size(), req_words.size() > 2 ? req_words[2] : -1);
        end
        for (int r = 0; r < req_idx.size() && r < 4; r++) begin
            n_cmp++;
            if (req_idx[r] !== base + 32'(16 * r) || req_len[r] !== 32'd16) begin
                n_err++;
                $display("FAIL bp_req[%0d]: got (%h,%0d) want (%h,16)", r, req_idx[r], req_len[r],
                         base + 32'(16 * r));
            end
        end
        n_cmp++;
        if (w_data.size() != 128) begin
            n_err++;
            $display("FAIL bp_count: got %0d words want 128", w_data.size());
        end
        for (int k = 0; k < w_data.size() && k < 128; k++) begin
            n_cmp++;
            if (w_data[k] !== exp_word(base, k) || w_last[k] !== (k == 127)) begin
                n_err++;
                $display("FAIL bp_word[%0d]: got %h last=%b want %h last=%b",
                         k, w_data[k], w_last[k], exp_word(base, k), (k == 127));
            end
        end
        n_cmp++;
        if (stab_err != 0) begin
            n_err++;
            $display("FAIL bp_stable: got %0d changes while stalled want 0", stab_err);
        end
    endtask

    task automatic test_zero_len();
        clear_logs();
        start_job(32'h700, 32'd0);
        repeat (4) @(negedge clk);
        n_cmp++;
        if (req_idx.size() != 0) begin
            n_err++;
            $display("FAIL zero_req: got %0d reqs want 0", req_idx.size());
        end
        n_cmp++;
        if (done_cnt != 1 || done_cyc != conf_cyc) begin
            n_err++;
            $display("FAIL zero_done: got %0d pulses at cyc %0d want 1 at cyc %0d",
                     done_cnt, done_cyc, conf_cyc);
        end
        n_cmp++;
        if (debug[2:0] !== 3'd0 || w_data.size() != 0) begin
            n_err++;
            $display("FAIL zero_idle: got state=%0d words=%0d want 0 0", debug[2:0], w_data.size());
        end
    endtask

    task automatic test_stall_ignore();
        int k;
        clear_logs();
        ctrl_rdy_en = 1'b0;
        chnl_en = 1'b0;
        start_job(32'h300, 32'd2);
        k = 0;
        while (!dma_read_ctrl_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        for (int c = 0; c < 10; c++) begin
            n_cmp++;
            if ({dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length} !==
                {1'b1, 32'h300, 32'd2}) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got v=%b idx=%h len=%0d want 1 300 2", c,
                         dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length);
            end
            @(negedge clk);
        end
        ctrl_rdy_en = 1'b1;
        k = 0;
        while (debug[2:0] !== 3'd2 && k < 20) begin
            @(negedge clk);
            k++;
        end
        conf_info_src_index = 32'h900;
        conf_info_num_beats = 32'd7;
        conf_done = 1'b1;
        @(negedge clk);
        conf_done = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (debug[2:0] !== 3'd2 || req_idx.size() != 1) begin
            n_err++;
            $display("FAIL stall_ignore: got state=%0d reqs=%0d want 2 1", debug[2:0], req_idx.size());
        end
        chnl_en = 1'b1;
        wait_done(200);
        n_cmp++;
        if (req_idx.size() != 1 || w_data.size() != 4) begin
            n_err++;
            $display("FAIL stall_job: got reqs=%0d words=%0d want 1 4", req_idx.size(), w_data.size());
        end
        for (int w = 0; w < w_data.size() && w < 4; w++) begin
            n_cmp++;
            if (w_data[w] !== exp_word(32'h300, w) || w_last[w] !== (w == 3)) begin
                n_err++;
                $display("FAIL stall_word[%0d]: got %h last=%b want %h last=%b",
                         w, w_data[w], w_last[w], exp_word(32'h300, w), (w == 3));
            end
        end
    endtask

    task automatic test_reset_mid();
        int k;
        clear_logs();
        start_job(32'h500, 32'd20);
        k = 0;
        while (debug[31:16] < 16'd5 && k < 100) begin
            @(negedge clk);
            k++;
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
             dma_read_chnl_ready, smp_valid, smp_data, smp_last, fetch_done, debug} !== 133'd0 ||
            dma_read_ctrl_data_size !== 3'b011) begin
            n_err++;
            $display("FAIL rstmid_outputs: got ctrl_v=%b chnl_rdy=%b sv=%b sd=%h fd=%b debug=%h size=%b, want 0s size 011",
                     dma_read_ctrl_valid, dma_read_chnl_ready, smp_valid, smp_data, fetch_done, debug,
                     dma_read_ctrl_data_size);
        end
        n_cmp++;
        if (done_cnt != 0) begin
            n_err++;
            $display("FAIL rstmid_nodone: got %0d pulses want 0", done_cnt);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_logs();
        start_job(32'h600, 32'd2);
        wait_done(200);
        n_cmp++;
        if (req_idx.size() != 1 || req_idx[0] !== 32'h600 || req_len[0] !== 32'd2 || w_data.size() != 4) begin
            n_err++;
            $display("FAIL rstmid_job: got reqs=%0d words=%0d want 1 req (600,2), 4 words",
                     req_idx.size(), w_data.size());
        end
        for (int w = 0; w < w_data.size() && w < 4; w++) begin
            n_cmp++;
            if (w_data[w] !== exp_word(32'h600, w) || w_last[w] !== (w == 3)) begin
                n_err++;
                $display("FAIL rstmid_word[%0d]: got %h last=%b want %h last=%b",
                         w, w_data[w], w_last[w], exp_word(32'h600, w), (w == 3));
            end
        end
        n_cmp++;
        if (done_cnt != 1) begin
            n_err++;
            $display("FAIL rstmid_done: got %0d pulses want 1", done_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_multi_burst();
        test_backpressure();
        test_zero_len();
        test_stall_ignore();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
